// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the divided-clock monitors.
package clk_mon_pkg;

  localparam int unsigned CLK_MON_CNT_W = 8;
  localparam int unsigned CLK_MON_ERR_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    MEASURE = 2'd2
  } mon_state_e;

  // Increment that sticks at the all-ones value of a width-bit field (width < 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_v;
    max_v = (32'd1 << width) - 32'd1;
    return (value >= max_v) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/clk_div_monitor_if.sv
// Control/status bundle between a divider checker and its owner.
interface clk_div_monitor_if import clk_mon_pkg::*; #(
  parameter int unsigned CNT_W = CLK_MON_CNT_W,
  parameter int unsigned ERR_W = CLK_MON_ERR_W
);

  logic             enable;
  logic             div_clk;
  logic [CNT_W-1:0] expected_div;
  logic             clr_err;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic [CNT_W-1:0] high_cnt;
  logic             locked;
  logic             stuck;
  logic             err_sticky;
  logic [ERR_W-1:0] mismatch_cnt;

  modport master (
    output enable, div_clk, expected_div, clr_err,
    input  period, period_valid, high_cnt, locked, stuck, err_sticky, mismatch_cnt
  );

  modport slave (
    input  enable, div_clk, expected_div, clr_err,
    output period, period_valid, high_cnt, locked, stuck, err_sticky, mismatch_cnt
  );

endinterface

// File: rtl/clk_mon_edge_det.sv
// Two-flop sampler of a clk_in-derived signal with rise/fall pulses.
module clk_mon_edge_det (
  input  logic clk_in,
  input  logic reset,
  input  logic sig,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic s0_q;
  logic s1_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
    end else begin
      s0_q <= sig;
      s1_q <= s0_q;
    end
  end

  assign level  = s0_q;
  assign rise_c = s0_q & ~s1_q;
  assign fall_c = ~s0_q & s1_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures div_clk periods in clk_in cycles, tracks lock against expected_div,
// counts mismatches and flags a stuck divided clock.
module clk_div_monitor import clk_mon_pkg::*; #(
  parameter int unsigned CNT_W      = CLK_MON_CNT_W,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned ERR_W      = CLK_MON_ERR_W
) (
  input  logic             clk_in,
  input  logic             reset,
  clk_div_monitor_if.slave bus
);

  localparam int unsigned RUN_W = $clog2(LOCK_COUNT + 1);

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             pv_q, pv_d, locked_q, locked_d, stuck_q, stuck_d, err_q, err_d;
  logic [ERR_W-1:0] mcnt_q, mcnt_d;

  logic             s0;
  logic             rise_c;
  logic             unused_fall_c;
  logic             mismatch_c;
  logic             timeout_c;
  logic [ERR_W-1:0] mcnt_base_c;

  clk_mon_edge_det u_edge (
    .clk_in (clk_in),
    .reset  (reset),
    .sig    (bus.div_clk),
    .level  (s0),
    .rise_c (rise_c),
    .fall_c (unused_fall_c)
  );

  logic [CNT_W-1:0] cnt_inc_c, hcnt_inc_c;
  logic [RUN_W-1:0] run_next_c;
  logic             match_c, at_timeout_c;

  assign cnt_inc_c    = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
  assign hcnt_inc_c   = CNT_W'(sat_inc(32'(hcnt_q), CNT_W));
  assign run_next_c   = (run_q == RUN_W'(LOCK_COUNT)) ? run_q : run_q + RUN_W'(1);
  // Periods below 2 cannot be produced by a real divider, so they never match.
  assign match_c      = (cnt_q == bus.expected_div) && (bus.expected_div >= CNT_W'(2));
  assign at_timeout_c = (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;
    period_d    = period_q;
    high_d      = high_q;
    run_d       = run_q;
    locked_d    = locked_q;
    pv_d        = 1'b0;
    stuck_d     = 1'b0;
    mismatch_c  = 1'b0;
    timeout_c   = 1'b0;
    mcnt_base_c = mcnt_q;

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        hcnt_d   = '0;
        run_d    = '0;
        locked_d = 1'b0;
        state_d  = ACQUIRE;
      end
      ACQUIRE: begin
        if (rise_c) begin
          cnt_d   = CNT_W'(1);
          hcnt_d  = CNT_W'(1);
          state_d = MEASURE;
        end else if (at_timeout_c) begin
          stuck_d   = 1'b1;
          timeout_c = 1'b1;
          locked_d  = 1'b0;
          run_d     = '0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end
      MEASURE: begin
        if (rise_c) begin
          period_d = cnt_q;
          high_d   = hcnt_q;
          pv_d     = 1'b1;
          cnt_d    = CNT_W'(1);
          hcnt_d   = CNT_W'(1);
          if (match_c) begin
            run_d    = run_next_c;
            locked_d = (run_next_c == RUN_W'(LOCK_COUNT));
          end else begin
            run_d      = '0;
            locked_d   = 1'b0;
            mismatch_c = 1'b1;
          end
        end else if (at_timeout_c) begin
          stuck_d   = 1'b1;
          timeout_c = 1'b1;
          locked_d  = 1'b0;
          run_d     = '0;
          cnt_d     = '0;
          hcnt_d    = '0;
          state_d   = ACQUIRE;
        end else begin
          cnt_d = cnt_inc_c;
          if (s0) hcnt_d = hcnt_inc_c;
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable overrides any rise or timeout seen this cycle.
    if (!bus.enable) begin
      state_d    = IDLE;
      cnt_d      = '0;
      hcnt_d     = '0;
      run_d      = '0;
      locked_d   = 1'b0;
      period_d   = period_q;
      high_d     = high_q;
      pv_d       = 1'b0;
      stuck_d    = 1'b0;
      mismatch_c = 1'b0;
      timeout_c  = 1'b0;
    end

    // Clear first, then count, so a same-cycle error survives the clear.
    if (bus.clr_err) mcnt_base_c = '0;
    mcnt_d = mismatch_c ? ERR_W'(sat_inc(32'(mcnt_base_c), ERR_W)) : mcnt_base_c;
    err_d  = (err_q & ~bus.clr_err) | ((mismatch_c | timeout_c) & locked_q);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      run_q    <= '0;
      pv_q     <= 1'b0;
      locked_q <= 1'b0;
      stuck_q  <= 1'b0;
      err_q    <= 1'b0;
      mcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      run_q    <= run_d;
      pv_q     <= pv_d;
      locked_q <= locked_d;
      stuck_q  <= stuck_d;
      err_q    <= err_d;
      mcnt_q   <= mcnt_d;
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = pv_q;
  assign bus.high_cnt     = high_q;
  assign bus.locked       = locked_q;
  assign bus.stuck        = stuck_q;
  assign bus.err_sticky   = err_q;
  assign bus.mismatch_cnt = mcnt_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor: directed div_clk waveforms plus a divide-by-3 source.
module tb_clk_div_monitor;
  import clk_mon_pkg::*;

  localparam int unsigned CNT_W      = 8;
  localparam int unsigned ERR_W      = 8;
  localparam int unsigned LOCK_COUNT = 4;
  localparam int unsigned TIMEOUT    = 255;

  typedef struct {
    string name;
    bit    is_stuck;
    int    period;
    int    high;
    bit    locked;
    bit    err;
    int    mcnt;
  } exp_t;

  logic clk_in = 1'b0;
  logic reset;
  logic div_drv;
  logic use_div;
  logic [1:0] dcnt;
  logic div_ref;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   last_valid_cyc = 0;
  exp_t expq[$];
  exp_t e;
  bit   ok;

  always #5 clk_in = ~clk_in;

  clk_div_monitor_if #(.CNT_W(CNT_W), .ERR_W(ERR_W)) bus ();

  clk_div_monitor #(
    .CNT_W(CNT_W), .LOCK_COUNT(LOCK_COUNT), .TIMEOUT(TIMEOUT), .ERR_W(ERR_W)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  // Divide-by-3 source: one cycle high, two low.
  always @(posedge clk_in) begin
    if (reset) dcnt <= 2'd0;
    else       dcnt <= (dcnt == 2'd2) ? 2'd0 : dcnt + 2'd1;
  end
  assign div_ref     = (dcnt == 2'd0);
  assign bus.div_clk = use_div ? div_ref : div_drv;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic push_v(input string n, input int p, input int h, input bit l, input bit err, input int m);
    exp_t x;
    x = '{name: n, is_stuck: 1'b0, period: p, high: h, locked: l, err: err, mcnt: m};
    expq.push_back(x);
  endtask

  task automatic push_s(input string n, input bit err, input int m);
    exp_t x;
    x = '{name: n, is_stuck: 1'b1, period: 0, high: 0, locked: 1'b0, err: err, mcnt: m};
    expq.push_back(x);
  endtask

  // One div_clk period of p cycles, h of them high; clr_err pulsed at index clr_idx.
  task automatic drive_period(input int p, input int h, input int clr_idx);
    for (int i = 0; i < p; i++) begin
      div_drv     = (i < h);
      bus.clr_err = (i == clr_idx);
      tick();
    end
    bus.clr_err = 1'b0;
  endtask

  // Monitor: every valid or stuck pulse must match the head of the expectation queue.
  initial begin
    forever begin
      @(negedge clk_in);
      cyc++;
      if (!reset && (bus.period_valid || bus.stuck)) begin
        vectors++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event: valid=%0b stuck=%0b period=%0d", bus.period_valid, bus.stuck, bus.period);
        end else begin
          e  = expq.pop_front();
          ok = (bus.stuck == e.is_stuck) && (bus.period_valid == !e.is_stuck) &&
               (bus.locked == e.locked) && (bus.err_sticky == e.err) &&
               (int'(bus.mismatch_cnt) == e.mcnt);
          if (e.is_stuck) ok = ok && ((cyc - last_valid_cyc) == int'(TIMEOUT));
          else            ok = ok && (int'(bus.period) == e.period) && (int'(bus.high_cnt) == e.high);
          if (!ok)
            $display("FAIL %s: got valid=%0b stuck=%0b period=%0d high=%0d locked=%0b err=%0b mcnt=%0d gap=%0d, want stuck=%0b period=%0d high=%0d locked=%0b err=%0b mcnt=%0d gap=%0d",
                     e.name, bus.period_valid, bus.stuck, bus.period, bus.high_cnt, bus.locked,
                     bus.err_sticky, bus.mismatch_cnt, cyc - last_valid_cyc, e.is_stuck, e.period,
                     e.high, e.locked, e.err, e.mcnt, TIMEOUT);
          if (!ok) miscompares++;
        end
      end
      if (bus.period_valid) last_valid_cyc = cyc;
    end
  end

  initial begin
    reset            = 1'b1;
    use_div          = 1'b0;
    div_drv          = 1'b0;
    bus.enable       = 1'b1;
    bus.clr_err      = 1'b0;
    bus.expected_div = 8'd3;
    repeat (3) tick();
    check("rst_period", 32'(bus.period), 0);
    check("rst_valid",  32'(bus.period_valid), 0);
    check("rst_high",   32'(bus.high_cnt), 0);
    check("rst_locked", 32'(bus.locked), 0);
    check("rst_stuck",  32'(bus.stuck), 0);
    check("rst_err",    32'(bus.err_sticky), 0);
    check("rst_mcnt",   32'(bus.mismatch_cnt), 0);
    check("rst_state",  32'(dut.state_q), 32'(IDLE));

    // Lock at 3, one 4-cycle glitch, re-lock.
    reset = 1'b0;
    repeat (2) tick();
    push_v("lock_p1", 3, 1, 0, 0, 0);
    push_v("lock_p2", 3, 1, 0, 0, 0);
    push_v("lock_p3", 3, 1, 0, 0, 0);
    push_v("lock_p4", 3, 1, 1, 0, 0);
    push_v("lock_p5", 3, 1, 1, 0, 0);
    push_v("lock_p6", 3, 1, 1, 0, 0);
    push_v("glitch4", 4, 1, 0, 1, 1);
    push_v("relock1", 3, 1, 0, 1, 1);
    push_v("relock2", 3, 1, 0, 1, 1);
    push_v("relock3", 3, 1, 0, 1, 1);
    push_v("relock4", 3, 1, 1, 1, 1);
    push_v("relock5", 3, 1, 1, 1, 1);
    for (int k = 1; k <= 12; k++) drive_period((k == 7) ? 4 : 3, 1, -1);

    // Rise reporting relock5, then clr_err, then hold div_clk low until timeout.
    push_s("stuck_locked", 1, 0);
    div_drv = 1'b1; tick();
    div_drv = 1'b0; tick();
    check("err_held", 32'(bus.err_sticky), 1);
    bus.clr_err = 1'b1; tick();
    bus.clr_err = 1'b0;
    check("clr_err", 32'(bus.err_sticky), 0);
    check("clr_mcnt", 32'(bus.mismatch_cnt), 0);
    repeat (270) tick();
    check("stuck_unlocked", 32'(bus.locked), 0);

    // Restart: first rise is silent, four matches lock again.
    push_v("restart1", 3, 1, 0, 1, 0);
    push_v("restart2", 3, 1, 0, 1, 0);
    push_v("restart3", 3, 1, 0, 1, 0);
    push_v("restart4", 3, 1, 1, 1, 0);
    push_v("restart5", 3, 1, 1, 1, 0);
    for (int k = 0; k < 5; k++) drive_period(3, 1, -1);
    div_drv = 1'b1; tick();
    div_drv = 1'b0; tick();
    bus.enable = 1'b0; tick();
    check("dis_locked", 32'(bus.locked), 0);
    check("dis_state",  32'(dut.state_q), 32'(IDLE));
    check("dis_period", 32'(bus.period), 3);
    repeat (3) tick();

    // Re-enable; clr_err mid-stream, then clr_err colliding with a mismatch.
    bus.enable = 1'b1;
    tick();
    push_v("reen1", 3, 1, 0, 1, 0);
    push_v("reen2", 3, 1, 0, 1, 0);
    push_v("reen3", 3, 1, 0, 1, 0);
    push_v("reen4", 3, 1, 1, 1, 0);
    push_v("reen5", 3, 1, 1, 0, 0);
    push_v("reen6", 3, 1, 1, 0, 0);
    push_v("clr_vs_mismatch", 5, 2, 0, 1, 1);
    for (int k = 0; k < 4; k++) drive_period(3, 1, -1);
    drive_period(3, 1, 2);
    drive_period(3, 1, -1);
    drive_period(5, 2, -1);
    drive_period(3, 1, 1);
    bus.enable = 1'b0;
    tick();

    // Integration with the divide-by-3 source.
    bus.clr_err = 1'b1; tick();
    bus.clr_err = 1'b0;
    check("pre_int_mcnt", 32'(bus.mismatch_cnt), 0);
    check("pre_int_err",  32'(bus.err_sticky), 0);
    use_div    = 1'b1;
    bus.enable = 1'b1;
    push_v("div3_1", 3, 1, 0, 0, 0);
    push_v("div3_2", 3, 1, 0, 0, 0);
    push_v("div3_3", 3, 1, 0, 0, 0);
    push_v("div3_4", 3, 1, 1, 0, 0);
    push_v("div3_5", 3, 1, 1, 0, 0);
    push_v("div3_6", 3, 1, 1, 0, 0);
    for (int i = 0; i < 300 && expq.size() != 0; i++) @(negedge clk_in);
    bus.enable = 1'b0;
    check("div3_drain", 32'(expq.size()), 0);
    repeat (5) tick();
    check("final_queue_empty", 32'(expq.size()), 0);
    check("div3_mcnt", 32'(bus.mismatch_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
